ysyx_22040237_lsu: RTL and testbench
====================================

Name: ysyx_22040237_lsu

Overview:
Load/store unit directly downstream of the execute stage. It takes the effective address computed by execute (rd_data) plus store data and access attributes. It runs one aligned 64-bit data-memory transaction per request over a valid/ready request channel and a valid response channel. It then returns aligned, sign/zero-extended load data to writeback.

Parameters:
XLEN, 64, datapath and address width
RD_W, 5, destination register index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  request from execute
in_ready  out  1  LSU can accept a request (high only in IDLE)
in_load  in  1  load access
in_store  in  1  store access (in_load/in_store never both high)
in_size  in  2  0=B, 1=H, 2=W, 3=D
in_unsigned  in  1  zero-extend load result
in_addr  in  XLEN  effective address from execute
in_wdata  in  XLEN  store data, LSB-aligned
in_rd  in  RD_W  destination register
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1 = write
mem_req_addr  out  XLEN  in_addr with bits [2:0] cleared
mem_req_wdata  out  XLEN  lane-shifted store data
mem_req_wmask  out  8  byte-enable mask
mem_rsp_valid  in  1  read data valid (loads only)
mem_rsp_rdata  in  XLEN  aligned 64-bit read data
out_valid  out  1  result pulse to writeback
out_wen  out  1  register write enable (loads only)
out_rd  out  RD_W  destination register
out_rdata  out  XLEN  extended load data
out_err  out  1  misaligned access (feature only; otherwise tied 0)

Behaviour:
- Reset (async, rst=1): FSM to IDLE; all registered outputs 0; in_ready=1 after release.
- States: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture all in_* fields.
  - If load or store -> REQ. Otherwise -> DONE with out_wen=0, out_rdata=0.
- REQ:
  - mem_req_valid=1; addr, we, wdata and wmask held stable until mem_req_ready.
  - On handshake: store -> DONE; load -> WAIT_RSP.
- WAIT_RSP: on mem_rsp_valid, register the extracted data -> DONE. A response arriving in the same cycle as the handshake is not accepted; responses are only taken in WAIT_RSP.
- DONE:
  - out_valid=1 for exactly one cycle; out_wen=in_load.
  - -> IDLE. No back-pressure from writeback.
- Latency, zero memory wait:
  - Load: accept cycle 0, request cycle 1, response cycle 2, out_valid cycle 3.
  - Store: accept cycle 0, request cycle 1, out_valid cycle 2.
- Lane rules (sh = addr[2:0]*8):
  - wmask = {0x01,0x03,0x0F,0xFF}[size] << addr[2:0], truncated to 8 bits.
  - wdata = in_wdata << sh.
  - Load: raw = rdata >> sh; take the low 8/16/32/64 bits; sign-extend from the top bit unless in_unsigned. D ignores in_unsigned.
- Without the checker, an access crossing the 8-byte boundary is truncated to the bytes within the aligned word. This is defined behaviour.
- Reset in REQ or WAIT_RSP abandons the transaction. A late mem_rsp_valid seen in IDLE is ignored.
- Status outputs (out_valid, out_wen, out_err) are low in every state except DONE. out_rd and out_rdata hold their last value.

Optional Feature:
Macro YSYX_22040237_LSU_MISALIGN_CHK_EN.
- Enabled:
  - Misaligned means H with addr[0]!=0, W with addr[1:0]!=0, D with addr[2:0]!=0.
  - A misaligned access skips REQ and goes IDLE -> DONE with out_err=1 and out_wen=0.
  - No memory request is issued.
- Disabled: out_err is tied to 0 and truncation applies.

Decomposition:
- Shared package/defines:
  - size encodings (SIZE_B/H/W/D)
  - FSM state encodings
  - XLEN
- One sub-module, ysyx_22040237_lsu_lane: purely combinational. Computes wmask/wdata from addr and size, and extends/extracts load data. It is reused by the checker.

Test Plan:
- SB 0xAB to addr 0x1003, mem_req_ready=1 -> req addr 0x1000, wmask 0x08, wdata 0x00000000AB000000; out_valid at cycle 2 with out_wen=0.
- LB addr 0x2005, rdata 0x0000_8000_0000_0000 -> out_rdata 0xFFFFFFFFFFFFFF80; LBU same -> 0x80; out_valid at cycle 3; out_rd echoed.
- LW addr 0x3004, rdata 0x8765432100000000; mem_req_ready low 3 cycles, rsp 2 cycles late -> request held stable; out_rdata 0xFFFFFFFF87654321; in_ready low throughout.
- LD, then assert rst in WAIT_RSP, then mem_rsp_valid after release -> outputs 0, IDLE, response ignored, no out_valid.
- Non-memory request (in_load=in_store=0) -> no mem_req_valid; out_valid at cycle 1 with out_wen=0.
- Feature on: SH at 0x4001 -> no request, out_err=1 and out_valid at cycle 1. Feature off: wmask 0x06.

Source files
------------

// File: rtl/ysyx_22040237_lsu_pkg.sv
// Shared definitions for the load/store unit: datapath widths, access-size
// encodings and FSM state encodings.
package ysyx_22040237_lsu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned MASK_W = XLEN / 8;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

endpackage

// File: rtl/ysyx_22040237_lsu_lane.sv
// Byte-lane logic for the LSU (purely combinational).
//   addr_lo/size/is_unsigned : access attributes
//   wdata -> wdata_sh, wmask  : store data shifted into its lanes + byte enables
//   rdata -> rdata_ext        : load data extracted from its lanes and extended
//   misaligned                : natural-alignment violation, gated by chk_en
module ysyx_22040237_lsu_lane
    import ysyx_22040237_lsu_pkg::*;
(
    input  logic              chk_en,
    input  logic [2:0]        addr_lo,
    input  size_e             size,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [MASK_W-1:0] wmask,
    output logic [XLEN-1:0]   wdata_sh,
    output logic [XLEN-1:0]   rdata_ext,
    output logic              misaligned
);

    logic [5:0]        sh;
    logic [XLEN-1:0]   raw;
    logic [MASK_W-1:0] base_mask;
    logic              mis_raw;

    // Lane shift, mask and extension; bytes past the aligned word fall off.
    always_comb begin
        sh        = {addr_lo, 3'b000};
        raw       = rdata >> sh;
        base_mask = 8'h01;
        rdata_ext = raw;
        mis_raw   = 1'b0;
        case (size)
            SIZE_B: begin
                base_mask = 8'h01;
                rdata_ext = is_unsigned ? XLEN'(raw[7:0])
                                        : {{(XLEN-8){raw[7]}}, raw[7:0]};
            end
            SIZE_H: begin
                base_mask = 8'h03;
                rdata_ext = is_unsigned ? XLEN'(raw[15:0])
                                        : {{(XLEN-16){raw[15]}}, raw[15:0]};
                mis_raw   = addr_lo[0];
            end
            SIZE_W: begin
                base_mask = 8'h0F;
                rdata_ext = is_unsigned ? XLEN'(raw[31:0])
                                        : {{(XLEN-32){raw[31]}}, raw[31:0]};
                mis_raw   = |addr_lo[1:0];
            end
            SIZE_D: begin
                base_mask = 8'hFF;
                rdata_ext = raw;
                mis_raw   = |addr_lo;
            end
        endcase
        wmask      = base_mask << addr_lo;
        wdata_sh   = wdata << sh;
        misaligned = chk_en & mis_raw;
    end

endmodule

// File: rtl/ysyx_22040237_lsu.sv
// Load/store unit: one aligned 64-bit memory transaction per request.
//   in_*      : request from execute (accepted while in_ready)
//   mem_req_* : valid/ready request channel, fields held while pending
//   mem_rsp_* : read response, taken only while waiting for it
//   out_*     : one-cycle result pulse to writeback
// Define YSYX_22040237_LSU_MISALIGN_CHK_EN to flag misaligned accesses via
// out_err instead of issuing a truncated memory access.
module ysyx_22040237_lsu
    import ysyx_22040237_lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [RD_W-1:0]   in_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    output logic              out_valid,
    output logic              out_wen,
    output logic [RD_W-1:0]   out_rd,
    output logic [XLEN-1:0]   out_rdata,
    output logic              out_err
);

`ifdef YSYX_22040237_LSU_MISALIGN_CHK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [2:0]        addr_lo_q;
    size_e             size_q;
    logic              unsigned_q;
    logic              load_q;
    logic              err_q;

    logic              accept;
    logic              mem_c;
    logic              err_c;
    logic [2:0]        lane_addr;
    size_e             lane_size;
    logic [MASK_W-1:0] lane_wmask;
    logic [XLEN-1:0]   lane_wdata;
    logic [XLEN-1:0]   lane_rdata;
    logic              lane_mis;

    assign accept = in_valid && (state_q == ST_IDLE);
    assign mem_c  = in_load | in_store;
    assign err_c  = lane_mis & mem_c;

    // Lanes see the live request in IDLE, the captured attributes afterwards.
    assign lane_addr = (state_q == ST_IDLE) ? in_addr[2:0] : addr_lo_q;
    assign lane_size = (state_q == ST_IDLE) ? size_e'(in_size) : size_q;

    ysyx_22040237_lsu_lane u_lane (
        .chk_en      (CHK_EN),
        .addr_lo     (lane_addr),
        .size        (lane_size),
        .is_unsigned (unsigned_q),
        .wdata       (in_wdata),
        .rdata       (mem_rsp_rdata),
        .wmask       (lane_wmask),
        .wdata_sh    (lane_wdata),
        .rdata_ext   (lane_rdata),
        .misaligned  (lane_mis)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = (mem_c && !err_c) ? ST_REQ : ST_DONE;
            end
            ST_REQ: begin
                if (mem_req_ready) state_d = mem_req_we ? ST_DONE : ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (mem_rsp_valid) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
        endcase
    end

    // Request capture, memory request fields and result data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_lo_q     <= '0;
            size_q        <= SIZE_B;
            unsigned_q    <= 1'b0;
            load_q        <= 1'b0;
            err_q         <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            out_rd        <= '0;
            out_rdata     <= '0;
        end else begin
            if (accept) begin
                addr_lo_q  <= in_addr[2:0];
                size_q     <= size_e'(in_size);
                unsigned_q <= in_unsigned;
                load_q     <= in_load & ~err_c;
                err_q      <= err_c;
                out_rd     <= in_rd;
                if (mem_c && !err_c) begin
                    mem_req_we    <= in_store;
                    mem_req_addr  <= {in_addr[XLEN-1:3], 3'b000};
                    mem_req_wdata <= lane_wdata;
                    mem_req_wmask <= lane_wmask;
                end else begin
                    out_rdata <= '0;
                end
            end
            if ((state_q == ST_WAIT_RSP) && mem_rsp_valid) out_rdata <= lane_rdata;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign mem_req_valid = (state_q == ST_REQ);
    assign out_valid     = (state_q == ST_DONE);
    assign out_wen       = (state_q == ST_DONE) && load_q;
    assign out_err       = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
module tb_ysyx_22040237_lsu;
    import ysyx_22040237_lsu_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, in_load, in_store, in_unsigned;
    logic [1:0]        in_size;
    logic [XLEN-1:0]   in_addr, in_wdata;
    logic [RD_W-1:0]   in_rd;
    logic              mem_req_valid, mem_req_ready, mem_req_we;
    logic [XLEN-1:0]   mem_req_addr, mem_req_wdata;
    logic [MASK_W-1:0] mem_req_wmask;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rsp_rdata;
    logic              out_valid, out_wen, out_err;
    logic [RD_W-1:0]   out_rd;
    logic [XLEN-1:0]   out_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22040237_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .out_valid(out_valid), .out_wen(out_wen), .out_rd(out_rd),
        .out_rdata(out_rdata), .out_err(out_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_load = 0; in_store = 0; in_size = 0; in_unsigned = 0;
        in_addr = '0; in_wdata = '0; in_rd = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        #2;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", mem_req_valid); end
        n_cmp++; if (out_valid !== 1'b0 || out_wen !== 1'b0 || out_err !== 1'b0) begin n_bad++; $display("FAIL rst_status: got %b%b%b want 000", out_valid, out_wen, out_err); end
        n_cmp++; if (out_rdata !== 64'h0 || out_rd !== 5'd0) begin n_bad++; $display("FAIL rst_out_data: got %h/%0d want 0/0", out_rdata, out_rd); end
        n_cmp++; if (mem_req_addr !== 64'h0 || mem_req_wmask !== 8'h0) begin n_bad++; $display("FAIL rst_req_fields: got %h/%h want 0/0", mem_req_addr, mem_req_wmask); end
        tick(); tick();
        rst = 0;
        tick();
    endtask

    task automatic test_store_byte();
        in_valid = 1; in_store = 1; in_size = 2'd0; in_addr = 64'h1003; in_wdata = 64'hAB; in_rd = 5'd4;
        tick();                                         // cycle 1
        idle_inputs(); mem_req_ready = 1;
        n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL sb_req_valid: got %b want 1", mem_req_valid); end
        n_cmp++; if (mem_req_addr !== 64'h1000) begin n_bad++; $display("FAIL sb_req_addr: got %h want 1000", mem_req_addr); end
        n_cmp++; if (mem_req_wmask !== 8'h08) begin n_bad++; $display("FAIL sb_wmask: got %h want 08", mem_req_wmask); end
        n_cmp++; if (mem_req_wdata !== 64'h00000000AB000000) begin n_bad++; $display("FAIL sb_wdata: got %h want 00000000ab000000", mem_req_wdata); end
        n_cmp++; if (mem_req_we !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL sb_we_ready: got %b/%b want 1/0", mem_req_we, in_ready); end
        tick();                                         // cycle 2
        mem_req_ready = 0;
        n_cmp++; if (out_valid !== 1'b1 || out_wen !== 1'b0 || out_err !== 1'b0) begin n_bad++; $display("FAIL sb_done: got v%b w%b e%b want v1 w0 e0", out_valid, out_wen, out_err); end
        n_cmp++; if (mem_req_valid !== 1'b0 || out_rd !== 5'd4) begin n_bad++; $display("FAIL sb_done_fields: got %b/%0d want 0/4", mem_req_valid, out_rd); end
        tick();                                         // cycle 3
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL sb_after: got v%b r%b want v0 r1", out_valid, in_ready); end
    endtask

    task automatic test_load_byte();
        logic [XLEN-1:0] exp_val [2];
        exp_val[0] = 64'hFFFFFFFFFFFFFF80;
        exp_val[1] = 64'h0000000000000080;
        for (int u = 0; u < 2; u++) begin
            in_valid = 1; in_load = 1; in_size = 2'd0; in_unsigned = 1'(u);
            in_addr = 64'h2005; in_rd = 5'd10 + 5'(u);
            tick();                                     // cycle 1
            idle_inputs(); mem_req_ready = 1;
            n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 64'h2000) begin n_bad++; $display("FAIL lb%0d_req: got v%b we%b a%h want v1 we0 a2000", u, mem_req_valid, mem_req_we, mem_req_addr); end
            tick();                                     // cycle 2
            mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 64'h0000_8000_0000_0000;
            n_cmp++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL lb%0d_wait: got v%b rq%b want 0/0", u, out_valid, mem_req_valid); end
            tick();                                     // cycle 3
            idle_inputs();
            n_cmp++; if (out_valid !== 1'b1 || out_wen !== 1'b1) begin n_bad++; $display("FAIL lb%0d_done: got v%b w%b want 1/1", u, out_valid, out_wen); end
            n_cmp++; if (out_rdata !== exp_val[u]) begin n_bad++; $display("FAIL lb%0d_rdata: got %h want %h", u, out_rdata, exp_val[u]); end
            n_cmp++; if (out_rd !== 5'd10 + 5'(u)) begin n_bad++; $display("FAIL lb%0d_rd: got %0d want %0d", u, out_rd, 10 + u); end
            tick();
        end
    endtask

    task automatic test_load_word_stall();
        in_valid = 1; in_load = 1; in_size = 2'd2; in_addr = 64'h3004; in_rd = 5'd3;
        tick();                                         // cycle 1
        for (int c = 1; c <= 3; c++) begin
            mem_req_ready = 0;                          // keep offering a new request
            n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h3000 || mem_req_we !== 1'b0) begin n_bad++; $display("FAIL lw_hold%0d: got v%b a%h we%b want v1 a3000 we0", c, mem_req_valid, mem_req_addr, mem_req_we); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL lw_ready%0d: got %b want 0", c, in_ready); end
            tick();
        end
        // cycle 4: handshake; a response in this same cycle must be ignored
        idle_inputs(); mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_rdata = 64'h1111_1111_2222_2222;
        n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h3000) begin n_bad++; $display("FAIL lw_hs: got v%b a%h want v1 a3000", mem_req_valid, mem_req_addr); end
        tick();
        idle_inputs();
        for (int c = 5; c <= 6; c++) begin
            n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL lw_wait%0d: got v%b r%b rq%b want 000", c, out_valid, in_ready, mem_req_valid); end
            tick();
        end
        mem_rsp_valid = 1; mem_rsp_rdata = 64'h8765432100000000;
        tick();                                         // DONE
        idle_inputs();
        n_cmp++; if (out_valid !== 1'b1 || out_wen !== 1'b1 || out_rd !== 5'd3) begin n_bad++; $display("FAIL lw_done: got v%b w%b rd%0d want 1 1 3", out_valid, out_wen, out_rd); end
        n_cmp++; if (out_rdata !== 64'hFFFFFFFF87654321) begin n_bad++; $display("FAIL lw_rdata: got %h want ffffffff87654321", out_rdata); end
        tick();
    endtask

    task automatic test_non_mem();
        in_valid = 1; in_rd = 5'd9;
        tick();                                         // cycle 1
        idle_inputs();
        n_cmp++; if (out_valid !== 1'b1 || out_wen !== 1'b0 || mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL nm_done: got v%b w%b rq%b want 1 0 0", out_valid, out_wen, mem_req_valid); end
        n_cmp++; if (out_rdata !== 64'h0 || out_rd !== 5'd9) begin n_bad++; $display("FAIL nm_data: got %h/%0d want 0/9", out_rdata, out_rd); end
        tick();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL nm_after: got v%b r%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_load_double_unsigned();
        in_valid = 1; in_load = 1; in_size = 2'd3; in_unsigned = 1; in_addr = 64'h6000; in_rd = 5'd12;
        tick();
        idle_inputs(); mem_req_ready = 1;
        n_cmp++; if (mem_req_wmask !== 8'hFF || mem_req_addr !== 64'h6000) begin n_bad++; $display("FAIL ld_req: got m%h a%h want ff 6000", mem_req_wmask, mem_req_addr); end
        tick();
        idle_inputs(); mem_rsp_valid = 1; mem_rsp_rdata = 64'h8000_0000_0000_0001;
        tick();
        idle_inputs();
        n_cmp++; if (out_valid !== 1'b1 || out_rdata !== 64'h8000000000000001) begin n_bad++; $display("FAIL ld_rdata: got v%b %h want 1 8000000000000001", out_valid, out_rdata); end
        tick();
    endtask

    task automatic test_misaligned_half();
        in_valid = 1; in_store = 1; in_size = 2'd1; in_addr = 64'h4001; in_wdata = 64'h1234; in_rd = 5'd6;
        tick();                                         // cycle 1
        idle_inputs(); mem_req_ready = 1;
`ifdef YSYX_22040237_LSU_MISALIGN_CHK_EN
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL sh_noreq: got %b want 0", mem_req_valid); end
        n_cmp++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_wen !== 1'b0) begin n_bad++; $display("FAIL sh_err: got v%b e%b w%b want 1 1 0", out_valid, out_err, out_wen); end
        tick();
`else
        n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_wmask !== 8'h06) begin n_bad++; $display("FAIL sh_req: got v%b m%h want 1 06", mem_req_valid, mem_req_wmask); end
        n_cmp++; if (mem_req_wdata !== 64'h0000000000123400 || mem_req_addr !== 64'h4000) begin n_bad++; $display("FAIL sh_fields: got d%h a%h want 123400 4000", mem_req_wdata, mem_req_addr); end
        tick();
        idle_inputs();
        n_cmp++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_wen !== 1'b0) begin n_bad++; $display("FAIL sh_done: got v%b e%b w%b want 1 0 0", out_valid, out_err, out_wen); end
        tick();
`endif
        idle_inputs();
        n_cmp++; if (out_valid !== 1'b0 || out_err !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL sh_after: got v%b e%b r%b want 0 0 1", out_valid, out_err, in_ready); end
    endtask

    task automatic test_reset_in_wait();
        in_valid = 1; in_load = 1; in_size = 2'd3; in_addr = 64'h5008; in_rd = 5'd7;
        tick();
        idle_inputs(); mem_req_ready = 1;
        tick();                                         // now waiting for response
        idle_inputs();
        n_cmp++; if (in_ready !== 1'b0 || out_rd !== 5'd7) begin n_bad++; $display("FAIL rw_pre: got r%b rd%0d want 0 7", in_ready, out_rd); end
        rst = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rw_rst_state: got r%b rq%b v%b want 1 0 0", in_ready, mem_req_valid, out_valid); end
        n_cmp++; if (out_rd !== 5'd0 || out_rdata !== 64'h0 || mem_req_addr !== 64'h0) begin n_bad++; $display("FAIL rw_rst_regs: got rd%0d d%h a%h want 0 0 0", out_rd, out_rdata, mem_req_addr); end
        tick();
        rst = 0;
        tick();
        mem_rsp_valid = 1; mem_rsp_rdata = 64'hDEAD_BEEF_0000_0001;
        tick();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (out_valid !== 1'b0 || out_rdata !== 64'h0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL rw_late%0d: got v%b d%h r%b want 0 0 1", c, out_valid, out_rdata, in_ready); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_byte();
        test_load_word_stall();
        test_non_mem();
        test_load_double_unsigned();
        test_misaligned_half();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
